program_sequencer: RTL and testbench
====================================

# program_sequencer

Run controller for the instruction fetch path. Accepts a start request, pulses `init` with the program start address into the instruction memory, and enables the fetch unit while the datapath is not stalled. It stops fetching when the halt instruction appears and reports completion with a cycle count. It tracks which of the three program images the instruction memory is serving and refuses to start a fourth run.

## Interface

Parameters:
- `HALT_INST`, 9'h1FF — instruction word that terminates a program.
- `NUM_PROGS`, 3 — number of program images available; valid `prog_id` values are 1..NUM_PROGS.
- `MAX_CYCLES`, 4096 — watchdog limit in RUN cycles. Used only with `SEQ_WATCHDOG_EN`.

Ports:
- `clk` — input, 1 bit — single clock; all state updates on the rising edge.
- `rst_n` — input, 1 bit — reset; synchronous, active-low.
- `start` — input, 1 bit — run request; sampled only in IDLE or DONE.
- `start_address` — input, 8 bits — first PC of the program; latched when `start` is accepted.
- `inst` — input, 9 bits — current instruction from the instruction memory.
- `stall` — input, 1 bit — datapath busy; the PC must hold.
- `init` — output, 1 bit — one-cycle pulse to the instruction memory `init` input.
- `start_addr_out` — output, 8 bits — latched start address, driven to the instruction memory `startAddress` input.
- `fetch_unit_en` — output, 1 bit — PC advance enable.
- `busy` — output, 1 bit — high in INIT, WAIT and RUN.
- `done` — output, 1 bit — high in DONE.
- `all_done` — output, 1 bit — high once `prog_id` == NUM_PROGS and state is DONE.
- `prog_id` — output, 2 bits — index of the program currently loaded.
- `cycle_count` — output, 16 bits — number of RUN cycles in the current or last run.
- `timeout` — output, 1 bit — the last run ended by watchdog.

## Operation

States: IDLE, INIT, WAIT, RUN, DONE.

- **IDLE**
  - With `start`=1: latch `start_address`, go to INIT.
  - Otherwise stay in IDLE.
- **INIT** (one cycle)
  - `init`=1.
  - `prog_id` increments.
  - `cycle_count` and `timeout` clear.
  - Next state is WAIT.
- **WAIT** (one cycle)
  - Instruction memory PC has loaded; `inst` is now valid.
  - `fetch_unit_en`=0.
  - Next state is RUN.
- **RUN**
  - `fetch_unit_en` = !`stall` && (`inst` != HALT_INST).
  - `cycle_count` increments every cycle, stall cycles included, saturating at 16'hFFFF.
  - `inst` == HALT_INST: go to DONE. `fetch_unit_en` is 0 that cycle, so the PC stays on the halt word.
  - Halt is honoured even while `stall`=1.
- **DONE**
  - Holds `done`=1 and a frozen `cycle_count`.
  - With `start`=1 and `prog_id` < NUM_PROGS: go to INIT.
  - With `start`=1 and `prog_id` == NUM_PROGS: ignore it and stay in DONE.
- `start` is ignored in INIT, WAIT and RUN. It is not queued.
- Branch and jump decode stay in the datapath. This block gates only the enable.

## Timing

- Reset values:
  - State is IDLE.
  - `init`, `fetch_unit_en`, `busy`, `done`, `all_done` and `timeout` are 0.
  - `prog_id` is 0.
  - `cycle_count` is 0.
  - `start_addr_out` is 0.
- Start latency: `start` sampled at edge N gives `init`=1 during cycle N+1, WAIT during N+2, and the first possible `fetch_unit_en`=1 during N+3.
- All outputs except `fetch_unit_en` are registered.
- `fetch_unit_en` is combinational from state, `stall` and `inst`. The instruction memory samples it on the same edge.
- Reset mid-run: the block returns to IDLE within one edge and clears `prog_id`. The instruction memory has no reset, so its program select is not resynchronised. Integration must reload the instruction memory alongside `rst_n`.
- `rst_n` has priority over every other input on the same edge.

## Configuration

- `SEQ_WATCHDOG_EN` defined:
  - In RUN, when `cycle_count` == MAX_CYCLES-1 and `inst` != HALT_INST, the next state is DONE with `timeout`=1.
  - `fetch_unit_en` is 0 in that final cycle.
  - `timeout` holds until the next INIT.
- `SEQ_WATCHDOG_EN` not defined:
  - No cycle limit.
  - `timeout` is tied to 0.
  - `MAX_CYCLES` is unused.

## Test plan

1. Reset, then `start`=1 with `start_address`=8'h00, then HALT_INST presented 5 RUN cycles later. Required: `init` pulses exactly once at N+1, `prog_id`=1, 5 `fetch_unit_en` pulses, `done`=1, `cycle_count`=6.
2. During RUN, `stall`=1 for 3 cycles. Required: `fetch_unit_en`=0 for those 3 cycles and `cycle_count` still advances by 3.
3. Assert `start` while in RUN. Required: no `init` pulse and `prog_id` unchanged. Then three full runs: required `prog_id`=3 and `all_done`=1, and a fourth `start` produces no `init`.
4. HALT_INST arrives in the same cycle as `stall`=1. Required: DONE on the next edge and `fetch_unit_en`=0 in that cycle.
5. `rst_n`=0 in the middle of RUN. Required: next cycle shows IDLE, `busy`=0, `prog_id`=0 and `cycle_count`=0.
6. With `SEQ_WATCHDOG_EN` defined and MAX_CYCLES=16, no halt presented. Required: `done`=1, `timeout`=1 and `cycle_count`=16. A following run clears `timeout` during INIT.

Source files
------------

// File: rtl/program_sequencer.sv
// Run controller for the instruction fetch path: start/init handshake, fetch gating, halt detect.
// Optional RUN-cycle watchdog enabled by defining SEQ_WATCHDOG_EN.
module program_sequencer #(
   parameter logic [8:0]  HALT_INST  = 9'h1FF,
   parameter int unsigned NUM_PROGS  = 3,
   parameter int unsigned MAX_CYCLES = 4096
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  start_address,
   input  logic [8:0]  inst,
   input  logic        stall,
   output logic        init,
   output logic [7:0]  start_addr_out,
   output logic        fetch_unit_en,
   output logic        busy,
   output logic        done,
   output logic        all_done,
   output logic [1:0]  prog_id,
   output logic [15:0] cycle_count,
   output logic        timeout
);

   typedef enum logic [2:0] {StIdle, StInit, StWait, StRun, StDone} state_e;

`ifdef SEQ_WATCHDOG_EN
   localparam bit WdEn = 1'b1;
`else
   localparam bit WdEn = 1'b0;
`endif
   localparam logic [1:0]  LastProg = 2'(NUM_PROGS);
   localparam logic [15:0] WdLast   = 16'(MAX_CYCLES - 1);

   state_e state_q;
   logic   is_halt;
   logic   wd_hit;
   logic   can_start;
   logic   run_end;

   assign is_halt   = (inst == HALT_INST);
   assign wd_hit    = WdEn && (cycle_count == WdLast) && !is_halt;
   // Once every image has run, DONE refuses further starts.
   assign can_start = start && ((state_q == StIdle) ||
                                ((state_q == StDone) && (prog_id < LastProg)));
   assign run_end   = (state_q == StRun) && (is_halt || wd_hit);

   // Combinational so the instruction memory sees the halt/stall gate on the same edge.
   assign fetch_unit_en = (state_q == StRun) && !stall && !is_halt && !wd_hit;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= StIdle;
         init           <= 1'b0;
         start_addr_out <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         all_done       <= 1'b0;
         prog_id        <= '0;
         cycle_count    <= '0;
`ifdef SEQ_WATCHDOG_EN
         timeout        <= 1'b0;
`endif
      end else begin
         init <= 1'b0;
         if (can_start) begin
            state_q        <= StInit;
            init           <= 1'b1;
            start_addr_out <= start_address;
            prog_id        <= prog_id + 2'd1;
            cycle_count    <= '0;
            busy           <= 1'b1;
            done           <= 1'b0;
            all_done       <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
            timeout        <= 1'b0;
`endif
         end else begin
            unique case (state_q)
               StInit: state_q <= StWait;
               StWait: state_q <= StRun;
               StRun: begin
                  if (cycle_count != 16'hFFFF) begin
                     cycle_count <= cycle_count + 16'd1;
                  end
                  if (run_end) begin
                     state_q  <= StDone;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                     all_done <= (prog_id == LastProg);
`ifdef SEQ_WATCHDOG_EN
                     timeout  <= wd_hit;
`endif
                  end
               end
               default: ;
            endcase
         end
      end
   end

`ifndef SEQ_WATCHDOG_EN
   assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_program_sequencer.sv
// Scoreboard bench for program_sequencer: expected run results queued at start, checked at DONE.
module tb_program_sequencer;

   localparam logic [8:0] HALT = 9'h1FF;
   localparam int         WD   = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  start_address = '0;
   logic [8:0]  inst = '0;
   logic        stall = 1'b0;
   logic        init;
   logic [7:0]  start_addr_out;
   logic        fetch_unit_en;
   logic        busy;
   logic        done;
   logic        all_done;
   logic [1:0]  prog_id;
   logic [15:0] cycle_count;
   logic        timeout;

   always #5 clk = ~clk;

   program_sequencer #(
      .HALT_INST (HALT),
      .NUM_PROGS (3),
      .MAX_CYCLES(WD)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .start_address (start_address),
      .inst          (inst),
      .stall         (stall),
      .init          (init),
      .start_addr_out(start_addr_out),
      .fetch_unit_en (fetch_unit_en),
      .busy          (busy),
      .done          (done),
      .all_done      (all_done),
      .prog_id       (prog_id),
      .cycle_count   (cycle_count),
      .timeout       (timeout)
   );

   typedef struct {
      logic [15:0] cc;
      int          fe;
      logic [1:0]  prog;
      logic        tmo;
      logic        alld;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_fail = 0;
   int   model_prog = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One complete run: start, INIT, WAIT, then RUN until DONE with optional stall/start events.
   task automatic run_prog(input logic [7:0] addr, input int n_inst, input int stall_at,
                           input int stall_len, input bit halt_stall, input int start_at,
                           input bit wd);
      exp_t e;
      exp_t got;
      int   fetched;
      int   fe_cnt;
      bit   fin;
      bit   halt_now;
      bit   st;
      bit   exp_fe;
      fetched = 0;
      fe_cnt  = 0;
      fin     = 1'b0;
      e.prog  = 2'(model_prog + 1);
      e.cc    = wd ? 16'(WD) : 16'(n_inst + stall_len + 1);
      e.fe    = wd ? WD - 1 : n_inst;
      e.tmo   = wd;
      e.alld  = (model_prog + 1 == 3);
      sb.push_back(e);
      model_prog++;

      start = 1'b1;
      start_address = addr;
      inst = {1'b0, addr};
      stall = 1'b0;
      tick();
      start = 1'b0;
      n_cmp++;
      if (init !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || prog_id !== e.prog ||
          start_addr_out !== addr || timeout !== 1'b0 || cycle_count !== 16'd0) begin
         n_fail++;
         $display("FAIL init_cycle: got init=%b busy=%b done=%b prog=%0d addr=%h tmo=%b cc=%0d, required 1 1 0 %0d %h 0 0",
                  init, busy, done, prog_id, start_addr_out, timeout, cycle_count, e.prog, addr);
      end
      @(negedge clk);
      n_cmp++;
      if (fetch_unit_en !== 1'b0) begin
         n_fail++;
         $display("FAIL fe_in_init: got %b, required 0", fetch_unit_en);
      end
      tick();
      n_cmp++;
      if (init !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL wait_cycle: got init=%b busy=%b, required init=0 busy=1", init, busy);
      end
      @(negedge clk);
      n_cmp++;
      if (fetch_unit_en !== 1'b0) begin
         n_fail++;
         $display("FAIL fe_in_wait: got %b, required 0", fetch_unit_en);
      end
      tick();

      for (int k = 0; k < 200 && !fin; k++) begin
         halt_now = !wd && (fetched == n_inst);
         st = ((k >= stall_at) && (k < stall_at + stall_len)) || (halt_now && halt_stall);
         inst = halt_now ? HALT : 9'(addr + fetched);
         stall = st;
         start = (k == start_at);
         exp_fe = !st && !halt_now && !(wd && (k == WD - 1));
         @(negedge clk);
         n_cmp++;
         if (fetch_unit_en !== exp_fe || init !== 1'b0) begin
            n_fail++;
            $display("FAIL run_cycle %0d: got fe=%b init=%b, required fe=%b init=0",
                     k, fetch_unit_en, init, exp_fe);
         end
         if (fetch_unit_en === 1'b1) begin
            fetched++;
            fe_cnt++;
         end
         tick();
         start = 1'b0;
         if (k == start_at) begin
            n_cmp++;
            if (init !== 1'b0 || prog_id !== e.prog) begin
               n_fail++;
               $display("FAIL start_in_run: got init=%b prog=%0d, required init=0 prog=%0d",
                        init, prog_id, e.prog);
            end
         end
         if (done === 1'b1) fin = 1'b1;
      end
      stall = 1'b0;
      if (!fin) begin
         n_cmp++;
         n_fail++;
         $display("FAIL run_timeout: done never rose within 200 cycles, required done=1");
      end

      got = sb.pop_front();
      n_cmp++;
      if (done !== 1'b1 || busy !== 1'b0 || cycle_count !== got.cc || fe_cnt != got.fe ||
          prog_id !== got.prog || timeout !== got.tmo || all_done !== got.alld) begin
         n_fail++;
         $display("FAIL run_result: got done=%b busy=%b cc=%0d fe=%0d prog=%0d tmo=%b alld=%b, required 1 0 %0d %0d %0d %b %b",
                  done, busy, cycle_count, fe_cnt, prog_id, timeout, all_done,
                  got.cc, got.fe, got.prog, got.tmo, got.alld);
      end
      tick();
      n_cmp++;
      if (done !== 1'b1 || cycle_count !== got.cc) begin
         n_fail++;
         $display("FAIL done_hold: got done=%b cc=%0d, required done=1 cc=%0d",
                  done, cycle_count, got.cc);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b1;
      tick();
      tick();
      start = 1'b0;
      n_cmp++;
      if (init !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || all_done !== 1'b0 ||
          prog_id !== 2'd0 || cycle_count !== 16'd0 || start_addr_out !== 8'd0 ||
          timeout !== 1'b0 || fetch_unit_en !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: got init=%b busy=%b done=%b alld=%b prog=%0d cc=%0d addr=%h tmo=%b fe=%b, required all 0",
                  init, busy, done, all_done, prog_id, cycle_count, start_addr_out, timeout,
                  fetch_unit_en);
      end
      rst_n = 1'b1;
      tick();
      n_cmp++;
      if (busy !== 1'b0 || init !== 1'b0 || prog_id !== 2'd0) begin
         n_fail++;
         $display("FAIL idle_hold: got busy=%b init=%b prog=%0d, required 0 0 0", busy, init, prog_id);
      end
      model_prog = 0;
   endtask

   task automatic test_single_run();
      run_prog(8'h00, 5, -1, 0, 1'b0, -1, 1'b0);
   endtask

   task automatic test_stall();
      run_prog(8'h20, 4, 1, 3, 1'b0, -1, 1'b0);
   endtask

   task automatic test_back_to_back();
      run_prog(8'h40, 3, -1, 0, 1'b0, 1, 1'b0);
      start = 1'b1;
      start_address = 8'hEE;
      tick();
      start = 1'b0;
      n_cmp++;
      if (init !== 1'b0 || done !== 1'b1 || prog_id !== 2'd3 || all_done !== 1'b1 ||
          start_addr_out !== 8'h40) begin
         n_fail++;
         $display("FAIL fourth_start: got init=%b done=%b prog=%0d alld=%b addr=%h, required 0 1 3 1 40",
                  init, done, prog_id, all_done, start_addr_out);
      end
      tick();
      n_cmp++;
      if (init !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL fourth_start_late: got init=%b busy=%b, required 0 0", init, busy);
      end
   endtask

   task automatic test_reset_midrun();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      model_prog = 0;
      start = 1'b1;
      start_address = 8'h55;
      inst = 9'h001;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      tick();
      n_cmp++;
      if (busy !== 1'b1 || cycle_count !== 16'd2) begin
         n_fail++;
         $display("FAIL midrun_pre: got busy=%b cc=%0d, required busy=1 cc=2", busy, cycle_count);
      end
      rst_n = 1'b0;
      start = 1'b1;
      tick();
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0 || prog_id !== 2'd0 || cycle_count !== 16'd0 ||
          init !== 1'b0 || start_addr_out !== 8'd0) begin
         n_fail++;
         $display("FAIL midrun_reset: got busy=%b done=%b prog=%0d cc=%0d init=%b addr=%h, required 0 0 0 0 0 00",
                  busy, done, prog_id, cycle_count, init, start_addr_out);
      end
      @(negedge clk);
      n_cmp++;
      if (fetch_unit_en !== 1'b0) begin
         n_fail++;
         $display("FAIL midrun_fe: got %b, required 0", fetch_unit_en);
      end
      start = 1'b0;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_halt_stall();
      run_prog(8'h10, 2, -1, 0, 1'b1, -1, 1'b0);
   endtask

   task automatic test_watchdog();
`ifdef SEQ_WATCHDOG_EN
      run_prog(8'h80, 0, -1, 0, 1'b0, -1, 1'b1);
`else
      run_prog(8'h80, 20, -1, 0, 1'b0, -1, 1'b0);
`endif
      // Following run checks timeout is clear from INIT onward.
      run_prog(8'h90, 1, -1, 0, 1'b0, -1, 1'b0);
   endtask

   initial begin
      test_reset();
      test_single_run();
      test_stall();
      test_back_to_back();
      test_reset_midrun();
      test_halt_stall();
      test_watchdog();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
